// File: rtl/amci_sequencer.sv
// Command sequencer in front of an AMCI-style AXI master: a small command FIFO
// feeds a four-state FSM that issues one AMCI transaction at a time and returns an in-order response.
module amci_sequencer #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH       = 4,
  parameter int TIMEOUT          = 1024
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  // Command stream
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic                          CMD_OP,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   CMD_DATA,
  // Response stream
  output logic                          RSP_VALID,
  input  logic                          RSP_READY,
  output logic                          RSP_OP,
  output logic [C_AXI_DATA_WIDTH-1:0]   RSP_DATA,
  // AMCI write side
  output logic [C_AXI_ADDR_WIDTH-1:0]   AMCI_WADDR,
  output logic [C_AXI_DATA_WIDTH-1:0]   AMCI_WDATA,
  output logic                          AMCI_WRITE,
  input  logic                          AMCI_WIDLE,
  // AMCI read side
  output logic [C_AXI_ADDR_WIDTH-1:0]   AMCI_RADDR,
  output logic                          AMCI_READ,
  input  logic [C_AXI_DATA_WIDTH-1:0]   AMCI_RDATA,
  input  logic                          AMCI_RIDLE,
  // Status
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          TIMEOUT_ERR
);

  // Handshakes: a command transfers on the rising edge where CMD_VALID && CMD_READY;
  // a response transfers on the rising edge where RSP_VALID && RSP_READY. Once raised,
  // RSP_VALID and its payload hold until that transfer.

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W    = $clog2(TIMEOUT + 1);
  localparam int ENTRY_W = 1 + C_AXI_ADDR_WIDTH + C_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // FIFO state
  logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // FSM state and registered outputs
  state_t                      state_q;
  logic                        op_q;
  logic [C_AXI_ADDR_WIDTH-1:0] waddr_q;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [C_AXI_ADDR_WIDTH-1:0] raddr_q;
  logic                        write_q;
  logic                        read_q;
  logic                        rsp_valid_q;
  logic                        rsp_op_q;
  logic [C_AXI_DATA_WIDTH-1:0] rsp_data_q;
  logic [TO_W-1:0]             wait_cnt_q;
  logic [TO_W-1:0]             wait_cnt_inc;
  logic                        timeout_err_q;

  logic                        cmd_ready;
  logic                        push;
  logic                        pop;
  logic [ENTRY_W-1:0]          head;
  logic                        head_op;
  logic [C_AXI_ADDR_WIDTH-1:0] head_addr;
  logic [C_AXI_DATA_WIDTH-1:0] head_data;
  logic                        side_idle;

  // Ready is held low while reset is asserted so nothing is accepted into a FIFO being cleared.
  assign cmd_ready = M_AXI_ARESETN && (count_q < CNT_W'(FIFO_DEPTH));
  assign push      = CMD_VALID && cmd_ready;
  assign pop       = (state_q == ST_IDLE) && (count_q != '0) && AMCI_WIDLE && AMCI_RIDLE;

  assign head      = fifo_mem_q[rd_ptr_q];
  assign head_op   = head[ENTRY_W-1];
  assign head_addr = head[C_AXI_DATA_WIDTH +: C_AXI_ADDR_WIDTH];
  assign head_data = head[C_AXI_DATA_WIDTH-1:0];

  assign side_idle = op_q ? AMCI_RIDLE : AMCI_WIDLE;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    wait_cnt_inc = wait_cnt_q;
    if (wait_cnt_q != TO_W'(TIMEOUT)) begin
      wait_cnt_inc = wait_cnt_q + TO_W'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge M_AXI_ACLK) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {CMD_OP, CMD_ADDR, CMD_DATA};
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= ST_IDLE;
      op_q          <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      raddr_q       <= '0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_op_q      <= 1'b0;
      rsp_data_q    <= '0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            op_q <= head_op;
            if (head_op) begin
              raddr_q <= head_addr;
            end else begin
              waddr_q <= head_addr;
              wdata_q <= head_data;
            end
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          write_q    <= !op_q;
          read_q     <= op_q;
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          write_q <= 1'b0;
          read_q  <= 1'b0;
          // The idle flag is ignored while the start pulse is out: the master has not reacted yet.
          if (!write_q && !read_q && side_idle) begin
            rsp_valid_q <= 1'b1;
            rsp_op_q    <= op_q;
            rsp_data_q  <= op_q ? AMCI_RDATA : '0;
            state_q     <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_inc;
            if (wait_cnt_inc == TO_W'(TIMEOUT)) begin
              timeout_err_q <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign CMD_READY   = cmd_ready;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_OP      = rsp_op_q;
  assign RSP_DATA    = rsp_data_q;
  assign AMCI_WADDR  = waddr_q;
  assign AMCI_WDATA  = wdata_q;
  assign AMCI_WRITE  = write_q;
  assign AMCI_RADDR  = raddr_q;
  assign AMCI_READ   = read_q;
  assign FIFO_COUNT  = count_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: doc/amci_sequencer.md
AMCI_SEQUENCER -- requirements
Module: amci_sequencer

Interface
REQ-001 The block SHALL have parameter C_AXI_DATA_WIDTH, default 32, meaning the data width of commands, responses and the AMCI data ports.
REQ-002 The block SHALL have parameter C_AXI_ADDR_WIDTH, default 32, meaning the width of command addresses and the AMCI address ports.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of command-queue entries; it SHALL be a power of 2 and at least 2.
REQ-004 The block SHALL have parameter TIMEOUT, default 1024, meaning the number of WAIT-state cycles after which the timeout flag is set.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning); one clock; reset is asynchronous and active-low:
 M_AXI_ACLK  in  1  clock
 M_AXI_ARESETN  in  1  asynchronous active-low reset
 CMD_VALID  in  1  command-stream valid
 CMD_READY  out  1  command-stream ready
 CMD_OP  in  1  0 = write, 1 = read
 CMD_ADDR  in  C_AXI_ADDR_WIDTH  target address
 CMD_DATA  in  C_AXI_DATA_WIDTH  write data, ignored for reads
 RSP_VALID  out  1  response valid
 RSP_READY  in  1  response accepted
 RSP_OP  out  1  op of the completed command
 RSP_DATA  out  C_AXI_DATA_WIDTH  read data; 0 for writes
 AMCI_WADDR / AMCI_WDATA  out  ADDR / DATA  write request to the AXI master
 AMCI_WRITE  out  1  one-cycle write start pulse
 AMCI_WIDLE  in  1  write side idle
 AMCI_RADDR  out  C_AXI_ADDR_WIDTH  read address
 AMCI_READ  out  1  one-cycle read start pulse
 AMCI_RDATA  in  C_AXI_DATA_WIDTH  read result, valid when AMCI_RIDLE is high after a read
 AMCI_RIDLE  in  1  read side idle
 FIFO_COUNT  out  clog2(FIFO_DEPTH)+1  queued-entry count
 TIMEOUT_ERR  out  1  sticky timeout flag

Function
REQ-006 The command FIFO SHALL assert CMD_READY = (FIFO_COUNT < FIFO_DEPTH), combinationally from the count, and SHALL push {op, addr, data} on CMD_VALID && CMD_READY.
REQ-007 Read/write pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop SHALL leave FIFO_COUNT unchanged; no push SHALL occur when the FIFO is full; no pop SHALL occur when it is empty.
REQ-008 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-009 In IDLE, when FIFO_COUNT > 0 and AMCI_WIDLE && AMCI_RIDLE, the FSM SHALL pop the head entry, register its address/data onto AMCI_WADDR/AMCI_WDATA (write) or AMCI_RADDR (read), and go to ISSUE.
REQ-010 In ISSUE, exactly one of AMCI_WRITE or AMCI_READ (matching op) SHALL be high for exactly one cycle, and the FSM SHALL go to WAIT.
REQ-011 AMCI address/data outputs SHALL remain stable from ISSUE until the FSM leaves WAIT.
REQ-012 In WAIT, on the first cycle AMCI_WIDLE (write) or AMCI_RIDLE (read) is high, the FSM SHALL latch RSP_OP, latch RSP_DATA (AMCI_RDATA for reads, 0 for writes), and go to RESP.
REQ-013 In RESP, RSP_VALID SHALL be high and RSP_OP/RSP_DATA held stable until RSP_READY is sampled high; the FSM SHALL then go to IDLE and deassert RSP_VALID.
REQ-014 Latency: a command pushed into an empty FIFO at cycle T with the AMCI side idle SHALL pop at T+1 and have its AMCI pulse at T+2; with the AMCI side idle-returning at T+3, RSP_VALID SHALL be high at T+4.
REQ-015 Commands SHALL complete strictly in FIFO order, with at most one outstanding AMCI transaction.
REQ-016 A saturating WAIT-cycle counter SHALL clear on entry to WAIT; when it reaches TIMEOUT, TIMEOUT_ERR SHALL set and stay set until reset, and the FSM SHALL continue waiting (no abort).
REQ-017 RSP_READY held high continuously SHALL allow back-to-back commands with one IDLE cycle between responses.

Reset
REQ-018 While M_AXI_ARESETN is low, asynchronously: state = IDLE; FIFO emptied (FIFO_COUNT = 0, pointers 0); CMD_READY deasserted only during reset; RSP_VALID, AMCI_WRITE, AMCI_READ, TIMEOUT_ERR, RSP_OP, RSP_DATA and all AMCI address/data outputs = 0.
REQ-019 After reset release, CMD_READY SHALL go high on the first clock cycle.
REQ-020 Reset in any state SHALL discard queued and in-flight commands, with no response issued; the downstream master is reset by the same signal.

Verification
REQ-021 Write then read: write 0x10/0xDEADBEEF, then read 0x10 with the model returning 0xDEADBEEF -> AMCI_WRITE pulses once with AMCI_WADDR=0x10; RSP {0,0} then {1,0xDEADBEEF}, in order.
REQ-022 Full: RSP_READY=0; push 6 commands (FIFO_DEPTH=4) -> CMD_READY low once FIFO_COUNT=4 with one command in RESP; releasing RSP_READY drains all 5 accepted commands in order.
REQ-023 Latency: single write into an empty FIFO at T, model idle returns at T+3 -> AMCI_WRITE high only at T+2; RSP_VALID high at T+4.
REQ-024 Timeout: TIMEOUT=8; model holds AMCI_RIDLE low 20 cycles -> TIMEOUT_ERR set after the 8th WAIT cycle, response still delivered, flag stays 1.
REQ-025 Mid-op reset: assert reset during WAIT with 3 entries queued -> all outputs 0 immediately; after release, FIFO_COUNT=0 and no RSP_VALID appears.
REQ-026 Simultaneous push/pop: push at the same cycle as a pop with FIFO_COUNT=2 -> FIFO_COUNT stays 2; pointer wrap verified over 10 commands.
